serial_sample_responder: RTL and testbench
==========================================

Name: serial_sample_responder

Overview:
- Device-side end of the 12-bit serial sample link used by the VU-meter front end.
- Watches the host command line for a start bit, then shifts a latched 12-bit sample out MSB-first, one bit per clock.
- Used as the ADC stand-in for loopback and bench tests, and as the on-chip source when the sample comes from internal logic.
- Includes a 1-deep pending buffer so samples arriving mid-frame are not torn.

Parameters:
- WIDTH, 12, sample width in bits; must be >= 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- din  in  1  host command line; a 1 sampled in IDLE is the start bit.
- sample_in  in  WIDTH  new sample value.
- sample_valid  in  1  one-cycle strobe qualifying sample_in.
- dout  out  1  serial data to host, MSB first.
- busy  out  1  high while a frame is being shifted.
- done  out  1  one-cycle pulse after the last bit of a frame.
- overrun  out  1  sticky; a buffered sample was overwritten before use.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset clears everything:
  - state = IDLE, holding register H = 0, pending register P = 0, pending-valid pv = 0, bit counter = 0.
  - Outputs: dout = 0, busy = 0, done = 0, overrun = 0.
- All outputs are registered.
- States: IDLE, SHIFT.
- IDLE:
  - dout = H[WIDTH-1] (MSB pre-presented, so the host captures it on the same edge that samples the start bit).
  - busy = 0.
- Start:
  - In IDLE, din = 1 at posedge k -> go to SHIFT; the frame transmits H as it was before edge k.
  - After edge k+j (j = 0..WIDTH-2), dout = H[WIDTH-2-j].
  - busy = 1 after edges k .. k+WIDTH-2.
- End of frame:
  - At edge k+WIDTH-1 (host captures H[0]): return to IDLE.
  - done = 1 for exactly the following cycle.
  - dout = MSB of the post-update H.
- din during SHIFT is ignored (trailing command zeros and stray ones alike).
- din = 1 on the first IDLE cycle after a frame starts a new frame immediately (back-to-back allowed).
- Sample loading in IDLE, no start: sample_valid -> H <= sample_in; dout shows the new MSB after that edge.
- Sample loading on the start edge or during SHIFT:
  - sample_valid -> P <= sample_in, pv <= 1.
  - If pv was already 1, P is overwritten and overrun <= 1.
- Sample loading on the end-of-frame edge:
  - If sample_valid: H <= sample_in (newest wins); if pv = 1 as well, overrun <= 1.
  - Else if pv: H <= P.
  - pv <= 0 in both cases.
- overrun stays set until rst; there is no other clear.
- Reset mid-frame: immediate return to IDLE with dout = 0; any pending sample and the partial frame are discarded, and no done pulse occurs.
- Width rules: the counter is sized ceil(log2(WIDTH)); no arithmetic on sample data, bits are passed unmodified.

Test Plan:
- Load 12'hA5C in IDLE, pulse din = 1 one cycle, then din = 0 -> host capturing on the start edge and the next 11 edges reads 1010_0101_1100 = 0xA5C; done pulses one cycle after the 12th edge; busy high for 11 cycles.
- H = 0xFFF, sample_valid with 0x123 three cycles into the frame -> frame shifts 0xFFF; after done, dout = 0 (MSB of 0x123); next frame returns 0x123; overrun = 0.
- Two sample_valid strobes mid-frame (0x111, then 0x222) -> next frame yields 0x222; overrun = 1 and stays 1 through later frames.
- Start bit and sample_valid (0x800) on the same IDLE edge with H = 0x7FF -> current frame returns 0x7FF; following frame returns 0x800.
- din held at 1 continuously with H = 0x3C3 -> back-to-back frames each returning 0x3C3, no idle gap, done pulsing every 12 cycles; din = 1 inside frames causes no restart.
- Assert rst at bit 5 of a frame with pv = 1 -> dout = busy = done = 0 immediately; no done pulse; a subsequent start returns 0x000.

Source files
------------

// File: rtl/serial_sample_responder.sv
// Device end of the serial sample link: on a start bit, shifts the held sample out MSB-first.
// A 1-deep pending buffer keeps samples that arrive mid-frame from tearing the frame in flight.
module serial_sample_responder #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             dout,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] h, h_nx, p, p_nx;
  logic             pv, pv_nx;
  logic [CW-1:0]    cnt, cnt_nx, cnt_m1;
  logic             dout_nx, busy_nx, done_nx, ovr_nx;

  assign cnt_m1 = cnt - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (din) state_nx = SHIFT;
      SHIFT:   if (cnt == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // cnt holds the index of the bit currently on dout while shifting
  always_comb begin
    h_nx    = h;
    p_nx    = p;
    pv_nx   = pv;
    cnt_nx  = cnt;
    dout_nx = dout;
    busy_nx = busy;
    done_nx = 1'b0;
    ovr_nx  = overrun;
    case (state)
      IDLE: begin
        if (din) begin
          dout_nx = h[WIDTH-2];
          busy_nx = 1'b1;
          cnt_nx  = CW'(WIDTH - 2);
          if (sample_valid) begin
            p_nx  = sample_in;
            pv_nx = 1'b1;
            if (pv) ovr_nx = 1'b1;
          end
        end else begin
          busy_nx = 1'b0;
          if (sample_valid) h_nx = sample_in;
          dout_nx = h_nx[WIDTH-1];
        end
      end
      SHIFT: begin
        if (cnt == '0) begin
          busy_nx = 1'b0;
          done_nx = 1'b1;
          pv_nx   = 1'b0;
          // newest sample wins; dropping a pending one counts as overrun
          if (sample_valid) begin
            h_nx = sample_in;
            if (pv) ovr_nx = 1'b1;
          end else if (pv) begin
            h_nx = p;
          end
          dout_nx = h_nx[WIDTH-1];
        end else begin
          dout_nx = h[cnt_m1];
          cnt_nx  = cnt_m1;
          if (sample_valid) begin
            p_nx  = sample_in;
            pv_nx = 1'b1;
            if (pv) ovr_nx = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h       <= '0;
      p       <= '0;
      pv      <= 1'b0;
      cnt     <= '0;
      dout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      h       <= h_nx;
      p       <= p_nx;
      pv      <= pv_nx;
      cnt     <= cnt_nx;
      dout    <= dout_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      overrun <= ovr_nx;
    end
  end

endmodule

// File: tb/tb_serial_sample_responder.sv
// Directed bench for serial_sample_responder: host side captures dout on each rising edge.
module tb_serial_sample_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic [11:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        dout, busy, done, overrun;

  int checks = 0;
  int failures = 0;

  serial_sample_responder #(.WIDTH(12)) dut (
    .clk(clk), .rst(rst), .din(din), .sample_in(sample_in),
    .sample_valid(sample_valid), .dout(dout), .busy(busy),
    .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [11:0] v);
    sample_in = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  // Starts a frame and captures the 12 bits the host sees; optional strobes at bit indices s1/s2.
  task automatic frame(input bit hold, input int s1, input logic [11:0] v1,
                       input int s2, input logic [11:0] v2,
                       output logic [11:0] got, output int bcnt);
    got = '0;
    bcnt = 0;
    din = 1'b1;
    for (int i = 0; i < 12; i++) begin
      got = {got[10:0], dout};
      sample_valid = (i == s1) || (i == s2);
      sample_in = (i == s2) ? v2 : v1;
      tick();
      sample_valid = 1'b0;
      if (!hold) din = 1'b0;
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({dout, busy, done, overrun} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000", {dout, busy, done, overrun});
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [11:0] got;
    int bc;
    load(12'hA5C);
    checks++;
    if (dout !== 1'b1) begin failures++; $display("FAIL basic_msb got=%b exp=1", dout); end
    frame(1'b0, -1, '0, -1, '0, got, bc);
    checks++;
    if (got !== 12'hA5C) begin failures++; $display("FAIL basic_data got=%h exp=a5c", got); end
    checks++;
    if (bc !== 11) begin failures++; $display("FAIL basic_busy got=%0d exp=11", bc); end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL basic_done got=%b exp=1", done); end
    tick();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL basic_done_clear got=%b exp=0", done); end
  endtask

  task automatic test_pending();
    logic [11:0] got;
    int bc;
    load(12'hFFF);
    frame(1'b0, 3, 12'h123, -1, '0, got, bc);
    checks++;
    if (got !== 12'hFFF) begin failures++; $display("FAIL pend_cur got=%h exp=fff", got); end
    checks++;
    if (dout !== 1'b0) begin failures++; $display("FAIL pend_msb got=%b exp=0", dout); end
    tick();
    frame(1'b0, -1, '0, -1, '0, got, bc);
    checks++;
    if (got !== 12'h123) begin failures++; $display("FAIL pend_next got=%h exp=123", got); end
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL pend_ovr got=%b exp=0", overrun); end
    tick();
  endtask

  task automatic test_overrun();
    logic [11:0] got;
    int bc;
    frame(1'b0, 2, 12'h111, 5, 12'h222, got, bc);
    checks++;
    if (got !== 12'h123) begin failures++; $display("FAIL ovr_cur got=%h exp=123", got); end
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    tick();
    frame(1'b0, -1, '0, -1, '0, got, bc);
    checks++;
    if (got !== 12'h222) begin failures++; $display("FAIL ovr_next got=%h exp=222", got); end
    tick();
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_start_and_load();
    logic [11:0] got;
    int bc;
    load(12'h7FF);
    frame(1'b0, 0, 12'h800, -1, '0, got, bc);
    checks++;
    if (got !== 12'h7FF) begin failures++; $display("FAIL sl_cur got=%h exp=7ff", got); end
    tick();
    frame(1'b0, -1, '0, -1, '0, got, bc);
    checks++;
    if (got !== 12'h800) begin failures++; $display("FAIL sl_next got=%h exp=800", got); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [11:0] got;
    int bc;
    load(12'h3C3);
    for (int f = 0; f < 3; f++) begin
      frame(1'b1, -1, '0, -1, '0, got, bc);
      checks++;
      if (got !== 12'h3C3) begin failures++; $display("FAIL b2b_data%0d got=%h exp=3c3", f, got); end
      checks++;
      if (done !== 1'b1 || bc !== 11) begin
        failures++;
        $display("FAIL b2b_done%0d got=%b/%0d exp=1/11", f, done, bc);
      end
    end
    din = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle got=%b%b exp=00", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] got;
    int bc;
    int seen;
    din = 1'b1;
    tick();
    din = 1'b0;
    load(12'h555);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    #2;
    checks++;
    if ({dout, busy, done, overrun} !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid_out got=%b exp=0000", {dout, busy, done, overrun});
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      if (done || busy) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL rstmid_quiet got=%0d exp=0", seen); end
    frame(1'b0, -1, '0, -1, '0, got, bc);
    checks++;
    if (got !== 12'h000) begin failures++; $display("FAIL rstmid_data got=%h exp=000", got); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pending();
    test_overrun();
    test_start_and_load();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
